// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds the PC, issues one imem read at a time and hands words to decode.
// Optional build macro PC_ALIGN_CHECK_EN: force PC bits [1:0] to zero on every load and flag a sticky align_err.
module pc_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_timeout,
  output logic        align_err
);

  typedef enum logic {S_REQ = 1'b0, S_VALID = 1'b1} state_t;

  // Counter value after which the next silent request cycle ends in a timeout.
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_timeout;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_nxt;
  logic [31:0] w_pc_out_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_req_nxt;
  logic        w_timeout_nxt;
  logic        w_load;
  logic [31:0] w_load_val;

  function automatic logic [31:0] f_pc_fix(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    return {v[31:2], 2'b00};
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_inst_nxt    = r_inst;
    w_pc_out_nxt  = r_pc_out;
    w_cnt_nxt     = r_cnt;
    w_req_nxt     = r_req;
    w_timeout_nxt = 1'b0;
    w_load        = 1'b0;
    w_load_val    = r_pc;
    if (redirect_valid) begin
      // Redirect wins over everything, including an ack arriving this same cycle.
      w_load      = 1'b1;
      w_load_val  = redirect_pc;
      w_state_nxt = S_REQ;
      w_req_nxt   = 1'b1;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (!r_req) begin
            w_req_nxt = 1'b1;
          end else if (imem_ack) begin
            w_inst_nxt   = imem_rdata;
            w_pc_out_nxt = r_pc;
            w_state_nxt  = S_VALID;
            w_req_nxt    = 1'b0;
            w_cnt_nxt    = 8'd0;
          end else if (r_cnt == CNT_LAST) begin
            w_timeout_nxt = 1'b1;
            w_req_nxt     = 1'b0;
            w_cnt_nxt     = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        S_VALID: begin
          if (inst_ready && !stall) begin
            w_load      = 1'b1;
            w_load_val  = next_pc;
            w_state_nxt = S_REQ;
            w_req_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_VALID;
          end
        end
        default: begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
    w_pc_nxt = w_load ? f_pc_fix(w_load_val) : r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_inst    <= 32'd0;
      r_pc_out  <= 32'd0;
      r_cnt     <= 8'd0;
      r_req     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_pc_out  <= w_pc_out_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req     <= w_req_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_align_err;

  // Sticky until reset: any misaligned value offered to the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align_err <= 1'b0;
    end else if (w_load && (w_load_val[1:0] != 2'b00)) begin
      r_align_err <= 1'b1;
    end else begin
      r_align_err <= r_align_err;
    end
  end

  assign align_err = r_align_err;
`else
  assign align_err = 1'b0;
`endif

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign inst_valid    = (r_state == S_VALID);
  assign inst_out      = r_inst;
  assign pc_out        = r_pc_out;
  assign pc_plus4      = r_pc_out + 32'd4;
  assign fetch_timeout = r_timeout;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus a scoreboard of acked fetches.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_timeout;
  logic        align_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  pc_fetch #(.RESET_PC(RST_PC), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .fetch_timeout(fetch_timeout), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the oldest acked fetch and compare it against what decode sees.
  task automatic sb_pop();
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("inst_out", inst_out, e[31:0]);
      chk("pc_out", pc_out, e[63:32]);
      chk("pc_plus4", pc_plus4, e[63:32] + 32'd4);
    end
  endtask

  // Entered at request cycle 1; acks after dly cycles, ends in S_VALID.
  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] data, input int dly);
    for (int i = 0; i < dly; i++) begin
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
    end
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", imem_addr, exp_pc);
    chk("valid_pre", {31'd0, inst_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back({exp_pc, data});
    @(negedge clk);
    imem_ack = 1'b0;
    chk("valid", {31'd0, inst_valid}, 32'd1);
    chk("req_off", {31'd0, imem_req}, 32'd0);
    sb_pop();
  endtask

  // Accept the held instruction and move to the given next PC.
  task automatic advance(input logic [31:0] npc);
    inst_ready = 1'b1;
    next_pc    = npc;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("adv_valid", {31'd0, inst_valid}, 32'd0);
    chk("adv_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0; next_pc = 32'd0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_to", {31'd0, fetch_timeout}, 32'd0);
    chk("rst_align", {31'd0, align_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First fetch, acked on the second request cycle.
    fetch(RST_PC, 32'h2408_0005, 1);

    // Stall holds the instruction even with decode ready.
    stall = 1'b1; inst_ready = 1'b1; next_pc = 32'h0040_0004;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_pc", pc_out, RST_PC);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("unstall_addr", imem_addr, 32'h0040_0004);
    chk("unstall_req", {31'd0, imem_req}, 32'd1);

    // Ack coincident with redirect is dropped.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    @(negedge clk);
    imem_ack = 1'b0; redirect_valid = 1'b0;
    chk("redir_addr", imem_addr, 32'h0040_0100);
    chk("redir_valid", {31'd0, inst_valid}, 32'd0);
    fetch(32'h0040_0100, 32'h1111_2222, 2);

    // Redirect from S_VALID beats inst_ready; then pc_plus4 wrap.
    inst_ready = 1'b1; next_pc = 32'h0040_0104;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk("redir2_valid", {31'd0, inst_valid}, 32'd0);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
    chk("wrap", pc_plus4, 32'h0000_0000);

    // Never ack: timeout pulse in request cycle 16, one idle cycle, then reissue.
    advance(32'h0040_0200);
    for (int i = 1; i <= 15; i++) begin
      chk("to_req", {31'd0, imem_req}, 32'd1);
      chk("to_pulse_early", {31'd0, fetch_timeout}, 32'd0);
      @(negedge clk);
    end
    chk("to_pulse", {31'd0, fetch_timeout}, 32'd1);
    chk("to_req_gap", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("to_pulse_end", {31'd0, fetch_timeout}, 32'd0);
    chk("to_reissue", imem_addr, 32'h0040_0200);
    fetch(32'h0040_0200, 32'hABCD_0001, 1);

    // Misaligned next PC.
    advance(32'h0040_0006);
`ifdef PC_ALIGN_CHECK_EN
    chk("align_addr", imem_addr, 32'h0040_0004);
    chk("align_err", {31'd0, align_err}, 32'd1);
    fetch(32'h0040_0004, 32'h5555_0000, 0);
    chk("align_sticky", {31'd0, align_err}, 32'd1);
`else
    chk("align_addr", imem_addr, 32'h0040_0006);
    chk("align_err", {31'd0, align_err}, 32'd0);
    fetch(32'h0040_0006, 32'h5555_0000, 0);
`endif
    advance(32'h0040_0300);

    // Reset mid-request abandons it.
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_align", {31'd0, align_err}, 32'd0);
    chk("midrst_addr", imem_addr, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_req", {31'd0, imem_req}, 32'd1);
    chk("rerst_valid", {31'd0, inst_valid}, 32'd0);

    // Sequential fetches with random ack delay and random stalls.
    pc = RST_PC;
    for (int k = 0; k < 8; k++) begin
      int st;
      fetch(pc, $urandom, int'($urandom_range(0, 4)));
      st = int'($urandom_range(0, 2));
      stall = 1'b1; inst_ready = 1'b1;
      for (int j = 0; j < st; j++) begin
        @(negedge clk);
        chk("rnd_stall", pc_out, pc);
      end
      stall = 1'b0;
      pc = pc + 32'd4;
      advance(pc);
      chk("rnd_addr", imem_addr, pc);
    end

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL set the PC value loaded at reset.
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum cycles to wait for imem_ack before a retry (legal range 2..255).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 next_pc  in  32  SHALL carry the selected next PC from the PC-source 4:1 select stage.
REQ-006 redirect_valid  in  1  SHALL request a flush and redirect to redirect_pc (branch, jump or exception).
REQ-007 redirect_pc  in  32  SHALL carry the redirect target.
REQ-008 stall  in  1  SHALL hold the current PC and instruction when high.
REQ-009 imem_req  out  1  SHALL request an instruction-memory read.
REQ-010 imem_addr  out  32  SHALL carry the read address; equals pc.
REQ-011 imem_ack  in  1  SHALL mark imem_rdata valid for one cycle.
REQ-012 imem_rdata  in  32  SHALL carry the fetched instruction word.
REQ-013 inst_valid  out  1  SHALL mark inst_out and pc_out valid to decode.
REQ-014 inst_ready  in  1  SHALL mark decode accepting the instruction.
REQ-015 inst_out  out  32  SHALL carry the registered instruction word.
REQ-016 pc_out  out  32  SHALL carry the PC of inst_out.
REQ-017 pc_plus4  out  32  SHALL equal pc_out + 4, modulo 2^32, combinationally.
REQ-018 fetch_timeout  out  1  SHALL pulse for one cycle on each ack timeout.
REQ-019 align_err  out  1  SHALL flag a misaligned PC load (see Configuration).

Function
REQ-020 The FSM SHALL have two states: S_REQ (request outstanding) and S_VALID (instruction held).
REQ-021 In S_REQ: imem_req=1, imem_addr=pc, inst_valid=0; the address SHALL stay stable until imem_ack or a timeout.
REQ-022 In S_REQ, imem_ack without redirect_valid SHALL latch imem_rdata into inst_out and move to S_VALID the next cycle (fetch latency = ack cycle + 1).
REQ-023 In S_VALID: imem_req=0, inst_valid=1; inst_out and pc_out SHALL hold stable.
REQ-024 In S_VALID with inst_ready=1, stall=0 and redirect_valid=0: pc <= next_pc, go to S_REQ.
REQ-025 stall=1 SHALL block the REQ-024 transition; in S_REQ, stall SHALL NOT block the ack capture.
REQ-026 redirect_valid=1 in any state SHALL load pc <= redirect_pc, drop inst_valid the next cycle, go to S_REQ, clear the timeout counter, and take priority over stall, inst_ready and imem_ack.
REQ-027 An imem_ack in the same cycle as redirect_valid SHALL be discarded.
REQ-028 A timeout counter SHALL increment each S_REQ cycle without ack; on reaching ACK_TIMEOUT-1 it SHALL pulse fetch_timeout, drop imem_req for one cycle, clear, and reissue the same address.
REQ-029 pc_plus4 SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-030 With rst_n low: pc=RESET_PC, state=S_REQ, inst_out=0, inst_valid=0, fetch_timeout=0, align_err=0, counter=0.
REQ-031 imem_req SHALL be 0 while rst_n is low and SHALL assert on the first rising edge after deassertion, with imem_addr=RESET_PC.
REQ-032 A reset mid-request SHALL abandon the request; the memory SHALL NOT hold an ack across reset.

Configuration
REQ-033 With PC_ALIGN_CHECK_EN defined, any PC load with bits [1:0]!=0 SHALL set a sticky align_err (cleared only by reset) and load the value with bits [1:0] forced to 0.
REQ-034 Without PC_ALIGN_CHECK_EN, the PC SHALL load verbatim and align_err SHALL be tied to 0.

Verification
REQ-035 Release reset, ack on the 2nd request cycle with rdata=32'h2408_0005 -> imem_addr=32'h0040_0000; the next cycle inst_valid=1, inst_out=32'h2408_0005, pc_plus4=32'h0040_0004.
REQ-036 In S_VALID, hold stall=1 for 3 cycles with inst_ready=1 -> pc_out is unchanged; release stall with next_pc=32'h0040_0004 -> imem_addr=32'h0040_0004.
REQ-037 redirect_valid=1 with redirect_pc=32'h0040_0100 in the same cycle as imem_ack -> the ack is dropped and the next request address is 32'h0040_0100.
REQ-038 Never ack, ACK_TIMEOUT=16 -> fetch_timeout pulses at cycle 16, imem_req is low for 1 cycle, then the same address is reissued.
REQ-039 PC_ALIGN_CHECK_EN defined, next_pc=32'h0040_0006 -> imem_addr=32'h0040_0004 and align_err=1 until reset.
REQ-040 pc_out=32'hFFFF_FFFC -> pc_plus4=32'h0000_0000.
